// File: rtl/baby_ctrl_pkg.sv
// baby_ctrl_pkg: shared mode encoding and default widths for the Baby RAM controller
package baby_ctrl_pkg;
  localparam int BABY_ADDR_W = 5;
  localparam int BABY_DATA_W = 32;
  typedef enum logic [1:0] {
    HALT    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } mode_e;
endpackage

// File: rtl/baby_run_counter.sv
// baby_run_counter: saturating run-cycle counter with watchdog compare
// Ports: clock, reset_i (sync, active-low), clr (zero count), en (count this cycle),
//        count (current value), hit (enabled cycle at watchdog limit minus one)
module baby_run_counter #(
  parameter int CYCLE_W        = 32,
  parameter int MAX_RUN_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic               clr,
  input  logic               en,
  output logic [CYCLE_W-1:0] count,
  output logic               hit
);
  localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(MAX_RUN_CYCLES == 0 ? 0 : MAX_RUN_CYCLES - 1);
  always_ff @(posedge clock)
    if (!reset_i || clr) count <= '0;
    else if (en && !(&count)) count <= count + CYCLE_W'(1);
  // Firing on LIMIT lets the counter still step to MAX_RUN_CYCLES on the final run cycle.
  assign hit = (MAX_RUN_CYCLES != 0) && en && count == LIMIT;
endmodule

// File: rtl/baby_ram_controller.sv
// baby_ram_controller: run/halt sequencer and core/host arbiter for the Baby store
// Ports: clock, reset_i (sync, active-low); cpu_* core RAM port; stop_lamp_i/cpu_hold_o core control;
//        host_* load/debug access and run/halt pulses; mem_* external RAM port;
//        mode_o, run_cycles_o, timeout_o status
module baby_ram_controller
  import baby_ctrl_pkg::*;
#(
  parameter int ADDR_W         = BABY_ADDR_W,
  parameter int DATA_W         = BABY_DATA_W,
  parameter int CYCLE_W        = 32,
  parameter int MAX_RUN_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [DATA_W-1:0]  cpu_wdata_i,
  input  logic               cpu_rw_en_i,
  output logic [DATA_W-1:0]  cpu_rdata_o,
  input  logic               stop_lamp_i,
  output logic               cpu_hold_o,
  input  logic               host_req_i,
  input  logic               host_we_i,
  input  logic [ADDR_W-1:0]  host_addr_i,
  input  logic [DATA_W-1:0]  host_wdata_i,
  output logic               host_gnt_o,
  output logic               host_rvalid_o,
  output logic [DATA_W-1:0]  host_rdata_o,
  input  logic               host_run_i,
  input  logic               host_halt_i,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  output logic               mem_we_o,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  output logic [1:0]         mode_o,
  output logic [CYCLE_W-1:0] run_cycles_o,
  output logic               timeout_o
);
  mode_e mode;
  logic hold_q, rd_q, run_pending, timeout_q;
  logic gnt, cpu_own, run_ok, enter_run, wd_hit;
  logic [CYCLE_W-1:0] count;
  assign cpu_own   = reset_i && mode == RUN;
  assign gnt       = reset_i && host_req_i && mode != RUN;
  // A run may not start while the host is touching memory or still owed read data.
  assign run_ok    = !gnt && !rd_q;
  assign enter_run = mode == HALT && (host_run_i || run_pending) && run_ok;
  baby_run_counter #(.CYCLE_W(CYCLE_W), .MAX_RUN_CYCLES(MAX_RUN_CYCLES)) u_cnt (
    .clock  (clock),
    .reset_i(reset_i),
    .clr    (enter_run),
    .en     (mode == RUN),
    .count  (count),
    .hit    (wd_hit)
  );
  always_ff @(posedge clock) begin
    if (!reset_i) begin
      mode        <= HALT;
      hold_q      <= 1'b1;
      rd_q        <= 1'b0;
      run_pending <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      rd_q <= gnt && !host_we_i;
      if (mode == HALT) begin
        run_pending <= (host_run_i || run_pending) && !run_ok;
        if (enter_run) begin
          mode      <= RUN;
          hold_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      end else if (mode == RUN) begin
        if (wd_hit || host_halt_i) begin
          mode      <= HALT;
          hold_q    <= 1'b1;
          timeout_q <= wd_hit;
        end else if (stop_lamp_i) begin
          mode <= STOPPED;
        end
      end else if (host_halt_i) begin
        mode   <= HALT;
        hold_q <= 1'b1;
      end
    end
  end
  assign host_gnt_o    = gnt;
  assign host_rvalid_o = reset_i && rd_q;
  assign host_rdata_o  = mem_rdata_i;
  assign cpu_rdata_o   = mem_rdata_i;
  assign mem_addr_o    = cpu_own ? cpu_addr_i  : gnt ? host_addr_i  : '0;
  assign mem_wdata_o   = cpu_own ? cpu_wdata_i : gnt ? host_wdata_i : '0;
  assign mem_we_o      = cpu_own ? cpu_rw_en_i : gnt && host_we_i;
  assign mode_o        = reset_i ? mode : HALT;
  assign cpu_hold_o    = !reset_i || hold_q;
  assign run_cycles_o  = reset_i ? count : '0;
  assign timeout_o     = reset_i && timeout_q;
endmodule

// File: tb/tb_baby_ram_controller.sv
// tb_baby_ram_controller: directed scoreboard bench for baby_ram_controller
module tb_baby_ram_controller;
  localparam int AW = 5, DW = 32, CW = 32, MAXC = 10;
  logic clock = 1'b0;
  logic reset_i;
  logic [AW-1:0] cpu_addr_i, host_addr_i, mem_addr_o;
  logic [DW-1:0] cpu_wdata_i, cpu_rdata_o, host_wdata_i, host_rdata_o, mem_wdata_o, mem_rdata_i;
  logic cpu_rw_en_i, stop_lamp_i, cpu_hold_o, host_req_i, host_we_i, host_gnt_o, host_rvalid_o;
  logic host_run_i, host_halt_i, mem_we_o, timeout_o;
  logic [1:0] mode_o;
  logic [CW-1:0] run_cycles_o;
  typedef struct { logic [DW-1:0] d; int c; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [DW-1:0] ram [32];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  baby_ram_controller #(.ADDR_W(AW), .DATA_W(DW), .CYCLE_W(CW), .MAX_RUN_CYCLES(MAXC)) dut (
    .clock(clock), .reset_i(reset_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rw_en_i(cpu_rw_en_i), .cpu_rdata_o(cpu_rdata_o),
    .stop_lamp_i(stop_lamp_i), .cpu_hold_o(cpu_hold_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .host_run_i(host_run_i), .host_halt_i(host_halt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i),
    .mode_o(mode_o), .run_cycles_o(run_cycles_o), .timeout_o(timeout_o)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
    cyc <= cyc + 1;
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  always @(negedge clock) if (host_rvalid_o) begin
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rvalid_unexpected got=%0h want=no_rvalid", host_rdata_o);
    end else begin
      mon_e = q.pop_front();
      chk("rvalid_data", host_rdata_o, mon_e.d);
      chk("rvalid_cycle", cyc, mon_e.c);
    end
  end
  task automatic nxt();
    @(posedge clock);
    #2;
  endtask
  task automatic chk_reset(input string p);
    chk({p, "_mode"}, mode_o, 0);
    chk({p, "_hold"}, cpu_hold_o, 1);
    chk({p, "_gnt"}, host_gnt_o, 0);
    chk({p, "_rvalid"}, host_rvalid_o, 0);
    chk({p, "_mem_we"}, mem_we_o, 0);
    chk({p, "_mem_addr"}, mem_addr_o, 0);
    chk({p, "_mem_wdata"}, mem_wdata_o, 0);
    chk({p, "_run_cycles"}, run_cycles_o, 0);
    chk({p, "_timeout"}, timeout_o, 0);
  endtask
  task automatic run_to_timeout();
    for (int i = 0; i < MAXC; i++) begin
      nxt();
      host_run_i = 0;
      #1;
      chk("wd_mode", mode_o, 1);
      chk("wd_count", run_cycles_o, i);
      chk("wd_timeout_low", timeout_o, 0);
    end
    nxt();
    #1;
    chk("wd_halt", mode_o, 0);
    chk("wd_final_count", run_cycles_o, MAXC);
    chk("wd_timeout", timeout_o, 1);
    chk("wd_hold", cpu_hold_o, 1);
  endtask
  initial begin
    reset_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0; cpu_rw_en_i = 0; stop_lamp_i = 0;
    host_req_i = 1; host_we_i = 1; host_addr_i = 7; host_wdata_i = 32'h55; host_run_i = 1; host_halt_i = 0;
    nxt(); nxt(); #1;
    chk_reset("rst");
    nxt(); reset_i = 1; host_run_i = 0; host_addr_i = 5; host_wdata_i = 32'hDEADBEEF; #1;
    chk("wr_gnt", host_gnt_o, 1);
    chk("wr_we", mem_we_o, 1);
    chk("wr_addr", mem_addr_o, 5);
    chk("wr_data", mem_wdata_o, 32'hDEADBEEF);
    chk("wr_hold", cpu_hold_o, 1);
    nxt(); host_we_i = 0; host_run_i = 1; #1;
    chk("rd_gnt", host_gnt_o, 1);
    chk("rd_we", mem_we_o, 0);
    chk("rd_addr", mem_addr_o, 5);
    q.push_back('{32'hDEADBEEF, cyc + 1});
    nxt(); host_req_i = 0; host_run_i = 0; #1;
    chk("defer_mode_b", mode_o, 0);
    chk("defer_hold_b", cpu_hold_o, 1);
    nxt(); #1;
    chk("defer_mode_c", mode_o, 0);
    nxt(); host_req_i = 1; host_we_i = 1; host_addr_i = 9; host_wdata_i = 32'h12345678; cpu_addr_i = 12; #1;
    chk("run_mode", mode_o, 1);
    chk("run_hold", cpu_hold_o, 0);
    chk("run_cnt0", run_cycles_o, 0);
    chk("run_no_gnt", host_gnt_o, 0);
    chk("run_mem_addr", mem_addr_o, 12);
    chk("run_mem_we", mem_we_o, 0);
    nxt(); cpu_addr_i = 13; #1;
    chk("run_cnt1", run_cycles_o, 1);
    chk("run_no_gnt2", host_gnt_o, 0);
    chk("run_mem_addr2", mem_addr_o, 13);
    nxt(); stop_lamp_i = 1; #1;
    chk("run_cnt2", run_cycles_o, 2);
    chk("run_mode2", mode_o, 1);
    nxt(); stop_lamp_i = 0; #1;
    chk("stop_mode", mode_o, 2);
    chk("stop_hold", cpu_hold_o, 0);
    chk("stop_gnt", host_gnt_o, 1);
    chk("stop_we", mem_we_o, 1);
    chk("stop_addr", mem_addr_o, 9);
    chk("stop_cnt_hold", run_cycles_o, 3);
    nxt(); host_we_i = 0; host_run_i = 1; #1;
    chk("stop_rd_gnt", host_gnt_o, 1);
    q.push_back('{32'h12345678, cyc + 1});
    nxt(); host_req_i = 0; host_run_i = 0; host_halt_i = 1; #1;
    chk("stop_run_ignored", mode_o, 2);
    nxt(); host_halt_i = 0; host_run_i = 1; #1;
    chk("stop_to_halt", mode_o, 0);
    chk("stop_to_halt_hold", cpu_hold_o, 1);
    nxt(); host_run_i = 0; cpu_addr_i = 3; cpu_wdata_i = 32'hCAFEF00D; cpu_rw_en_i = 1;
    host_halt_i = 1; stop_lamp_i = 1; #1;
    chk("both_mode_run", mode_o, 1);
    chk("core_wr_we", mem_we_o, 1);
    chk("core_wr_addr", mem_addr_o, 3);
    chk("core_wr_data", mem_wdata_o, 32'hCAFEF00D);
    nxt(); cpu_rw_en_i = 0; host_halt_i = 0; stop_lamp_i = 0; host_req_i = 1; host_addr_i = 3; #1;
    chk("halt_wins", mode_o, 0);
    chk("halt_wins_hold", cpu_hold_o, 1);
    chk("core_rd_gnt", host_gnt_o, 1);
    q.push_back('{32'hCAFEF00D, cyc + 1});
    nxt(); host_req_i = 0; #1;
    nxt(); host_run_i = 1; #1;
    chk("wd_pre_mode", mode_o, 0);
    run_to_timeout();
    nxt(); host_run_i = 1; #1;
    chk("timeout_sticky", timeout_o, 1);
    chk("timeout_sticky_mode", mode_o, 0);
    run_to_timeout();
    nxt(); host_req_i = 1; host_we_i = 0; host_addr_i = 5; host_run_i = 1; #1;
    chk("rst_rd_gnt", host_gnt_o, 1);
    chk("rst_rd_mode", mode_o, 0);
    nxt(); reset_i = 0; host_run_i = 0; #1;
    chk_reset("rst_mid");
    nxt(); reset_i = 1; host_req_i = 0; #1;
    chk("rst_pend_clr", mode_o, 0);
    chk("rst_no_rvalid", host_rvalid_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_cnt", run_cycles_o, 0);
    nxt(); #1;
    chk("rst_pend_clr2", mode_o, 0);
    nxt(); #1;
    chk("sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/baby_ram_controller.md
# baby_ram_controller

Run/halt controller and memory arbiter for the Manchester Baby core. Owns the 32-word × 32-bit store (synchronous-read RAM, 1-cycle latency) and shares it between the core and a host load/debug port. The host can only reach memory while the core is held or stopped. The block also sequences the core's hold line, counts run cycles and enforces an optional run-cycle watchdog.

## Interface
Parameters:
- ADDR_W, 5, memory address width
- DATA_W, 32, memory word width
- CYCLE_W, 32, run-cycle counter width
- MAX_RUN_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
- clock  in  1  single clock, rising edge
- reset_i  in  1  synchronous, active-low reset
- cpu_addr_i  in  ADDR_W  core address (core ram_addr_o)
- cpu_wdata_i  in  DATA_W  core write data (core ram_data_o)
- cpu_rw_en_i  in  1  core write enable; 0 = read, 1 = write
- cpu_rdata_o  out  DATA_W  read data to core; equals mem_rdata_i
- stop_lamp_i  in  1  core stop lamp
- cpu_hold_o  out  1  holds the core in reset while 1
- host_req_i  in  1  host access request; level, held until granted
- host_we_i, host_addr_i, host_wdata_i  in  1/ADDR_W/DATA_W  host access fields; stable while host_req_i is 1
- host_gnt_o  out  1  access accepted this cycle
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  DATA_W  equals mem_rdata_i; qualified by host_rvalid_o
- host_run_i, host_halt_i  in  1  single-cycle command pulses
- mem_addr_o, mem_wdata_o, mem_we_o  out  ADDR_W/DATA_W/1  RAM port
- mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after address
- mode_o  out  2  current mode: HALT=0, RUN=1, STOPPED=2
- run_cycles_o  out  CYCLE_W  RUN cycles since last run start
- timeout_o  out  1  sticky flag: watchdog fired

## Operation
- States: HALT, RUN, STOPPED. Reset enters HALT.
- HALT:
  - cpu_hold_o = 1; host owns memory.
  - On host_run_i: go to RUN, provided no host access is granted that cycle and no host read is in flight.
  - If the run condition is not met, set run_pending. The transition is taken on the first cycle that satisfies the condition.
- RUN:
  - cpu_hold_o = 0; mem_* = cpu_*; host requests wait, with no grant.
  - On host_halt_i: go to HALT. The core access in that same cycle still completes.
  - On stop_lamp_i: go to STOPPED.
  - If host_halt_i and stop_lamp_i arrive together, HALT wins.
  - If the watchdog fires: go to HALT and set timeout_o.
- STOPPED:
  - cpu_hold_o = 0; host owns memory.
  - host_halt_i: go to HALT.
  - host_run_i: ignored. The host must halt first.
- Host access:
  - host_gnt_o = host_req_i while mode is HALT or STOPPED (combinational).
  - On a grant: mem_addr_o = host_addr_i and mem_we_o = host_we_i.
  - A write completes in the grant cycle.
  - For a read, host_rvalid_o pulses on the next cycle.
  - Back-to-back grants are allowed, one per cycle.
  - When the host owns memory and there is no grant, mem_we_o = 0 and mem_addr_o = 0.
- Run counter:
  - Cleared when RUN is entered from HALT.
  - Increments each RUN cycle and saturates at all-ones.
  - Holds its value in HALT and STOPPED.
- Watchdog:
  - Fires when MAX_RUN_CYCLES ≠ 0 and run_cycles_o == MAX_RUN_CYCLES - 1 during a RUN cycle.
  - timeout_o clears on the next accepted run.
- Reset mid-operation:
  - Any in-flight read is dropped; no host_rvalid_o is produced.
  - run_pending and timeout_o clear.

## Timing
- Values while reset_i = 0:
  - mode_o = HALT, cpu_hold_o = 1
  - host_gnt_o = 0, host_rvalid_o = 0
  - mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0
  - run_cycles_o = 0, timeout_o = 0
- A command pulse at edge N changes mode_o and cpu_hold_o at edge N+1. cpu_hold_o is registered and tracks mode.
- Host read granted in cycle N: host_rvalid_o = 1 in cycle N+1.
- Host write latency: 0 cycles (RAM write at the edge closing the grant cycle).
- Deferred run: RUN is entered one cycle after the last read's rvalid-producing grant cycle has retired.

## Structure
- Package baby_ctrl_pkg holds:
  - the mode enum (HALT, RUN, STOPPED)
  - the ADDR_W/DATA_W defaults
- Sub-module baby_run_counter: saturating CYCLE_W counter, clear/enable inputs, watchdog compare output.
- The FSM, run_pending flag and memory mux stay in the top module.

## Test plan
- Host writes 0xDEADBEEF to addr 5 in HALT, then reads addr 5 -> grants in consecutive cycles; rvalid one cycle after the read grant with rdata 0xDEADBEEF; cpu_hold_o = 1 throughout.
- host_run_i coincident with a read grant -> stays HALT that cycle; RUN on a later cycle with no grant and no read in flight; run_cycles_o counts 0, 1, 2…
- In RUN, host_req_i held high -> no host_gnt_o; mem_addr_o follows cpu_addr_i; stop_lamp_i = 1 -> STOPPED next cycle; the pending request is then granted.
- host_halt_i and stop_lamp_i in the same RUN cycle -> HALT; a core write to addr 3 in that cycle lands in RAM.
- MAX_RUN_CYCLES = 10, run started -> HALT after exactly 10 RUN cycles with run_cycles_o = 10; timeout_o = 1 until the next host_run_i.
- reset_i low one cycle after a read grant -> no rvalid; all outputs at reset values; mode_o = HALT.
